// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer scheduler.
// SPRITE_FLIP_EN adds a per-slot horizontal mirror bit to sprite_entry_t.
package sprite_pkg;

  localparam int SPR_W    = 14;
  localparam int SPR_H    = 14;
  localparam int SPR_PIX  = 196;
  localparam int ACTIVE_W = 640;
  localparam int ACTIVE_H = 480;
  localparam int IMG_BITS = 4;

  typedef struct packed {
    logic [9:0]          x;
    logic [9:0]          y;
    logic [IMG_BITS-1:0] img;
    logic                en;
`ifdef SPRITE_FLIP_EN
    logic                flip_h;
`endif
  } sprite_entry_t;

  typedef enum logic [1:0] {
    DISPLAY,
    COMMIT,
    VBLANK
  } frame_state_e;

endpackage

// File: rtl/sprite_hit_unit.sv
// Combinational coverage test and sprite-local row/col for one slot.
// SPRITE_FLIP_EN mirrors the column when the slot's flip bit is set.
module sprite_hit_unit
  import sprite_pkg::*;
#(
  parameter int SCALE_LOG2 = 1
) (
  input  sprite_entry_t ent,
  input  logic [9:0]    draw_x,
  input  logic [9:0]    draw_y,
  output logic          hit,
  output logic [3:0]    row,
  output logic [3:0]    col
);

  localparam logic [10:0] SPAN_X = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] SPAN_Y = 11'(SPR_H << SCALE_LOG2);

  logic [10:0] dx;
  logic [10:0] dy;

  always_comb begin
    dx  = {1'b0, draw_x} - {1'b0, ent.x};
    dy  = {1'b0, draw_y} - {1'b0, ent.y};
    hit = ent.en && !dx[10] && !dy[10]
        && (dx < SPAN_X) && (dy < SPAN_Y);
    row = 4'(dy >> SCALE_LOG2);
    col = 4'(dx >> SCALE_LOG2);
`ifdef SPRITE_FLIP_EN
    if (ent.flip_h) begin
      col = 4'd13 - col;
    end
`endif
  end

endmodule

// File: rtl/sprite_layer_scheduler.sv
// Per-pixel sprite arbiter sharing one ROM; shadow table commits at vblank.
// SPRITE_FLIP_EN adds the cfg_flip_h port and horizontal mirroring.
module sprite_layer_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int NUM_IMAGES  = 4,
  parameter int SCALE_LOG2  = 1,
  localparam int SW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int IW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  localparam int AW = $clog2(NUM_IMAGES * SPR_PIX)
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          blank,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [SW-1:0] cfg_slot,
  input  logic [9:0]    cfg_x,
  input  logic [9:0]    cfg_y,
  input  logic [IW-1:0] cfg_img,
  input  logic          cfg_en,
`ifdef SPRITE_FLIP_EN
  input  logic          cfg_flip_h,
`endif
  output logic [AW-1:0] rom_address,
  input  logic [1:0]    rom_q,
  output logic          pix_valid,
  output logic          pix_hit,
  output logic [1:0]    pix_index,
  output logic          frame_start
);

  frame_state_e  state_q, state_d;
  sprite_entry_t shadow_q [NUM_SPRITES];
  sprite_entry_t shadow_d [NUM_SPRITES];
  sprite_entry_t active_q [NUM_SPRITES];
  sprite_entry_t active_d [NUM_SPRITES];
  sprite_entry_t wr_ent;

  logic          frame_start_q, frame_start_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          hit1_q, hit1_d;
  logic          blank1_q;
  logic          hit2_q;
  logic          blank2_q;

  logic [NUM_SPRITES-1:0] hit_v;
  logic [3:0]             row_v [NUM_SPRITES];
  logic [3:0]             col_v [NUM_SPRITES];

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit_unit #(
      .SCALE_LOG2(SCALE_LOG2)
    ) u_hit (
      .ent   (active_q[g]),
      .draw_x(DrawX),
      .draw_y(DrawY),
      .hit   (hit_v[g]),
      .row   (row_v[g]),
      .col   (col_v[g])
    );
  end

  always_comb begin
    state_d       = state_q;
    frame_start_d = 1'b0;
    cfg_ready     = 1'b1;
    unique case (state_q)
      VBLANK: begin
        if (DrawY == 10'd0) begin
          state_d       = DISPLAY;
          frame_start_d = 1'b1;
        end
      end
      DISPLAY: begin
        if (DrawY == 10'(ACTIVE_H)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d   = VBLANK;
        cfg_ready = 1'b0;
      end
      default: state_d = VBLANK;
    endcase
  end

  always_comb begin
    wr_ent     = '0;
    wr_ent.x   = cfg_x;
    wr_ent.y   = cfg_y;
    wr_ent.img = IMG_BITS'(cfg_img);
    wr_ent.en  = cfg_en;
`ifdef SPRITE_FLIP_EN
    wr_ent.flip_h = cfg_flip_h;
`endif
    shadow_d = shadow_q;
    active_d = active_q;
    if (cfg_valid && cfg_ready) begin
      shadow_d[cfg_slot] = wr_ent;
    end
    // Copy reads shadow_q, so a write landing at the same edge is excluded.
    if (state_q == COMMIT) begin
      active_d = shadow_q;
    end
  end

  // Lowest slot that covers the pixel owns it, even if its texel is clear.
  always_comb begin
    addr_d = '0;
    hit1_d = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (!hit1_d && hit_v[i]) begin
        hit1_d = 1'b1;
        addr_d = AW'(int'(active_q[i].img) * SPR_PIX
               + int'(row_v[i]) * SPR_W
               + int'(col_v[i]));
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= VBLANK;
      frame_start_q <= 1'b0;
      addr_q        <= '0;
      hit1_q        <= 1'b0;
      blank1_q      <= 1'b0;
      hit2_q        <= 1'b0;
      blank2_q      <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      frame_start_q <= frame_start_d;
      addr_q        <= addr_d;
      hit1_q        <= hit1_d;
      blank1_q      <= blank;
      hit2_q        <= hit1_q;
      blank2_q      <= blank1_q;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  // Stage-2 bits are aligned with the ROM's own output register.
  always_comb begin
    rom_address = addr_q;
    frame_start = frame_start_q;
    pix_valid   = blank2_q;
    pix_hit     = hit2_q && (rom_q != 2'd0) && blank2_q;
    pix_index   = pix_hit ? rom_q : 2'd0;
  end

endmodule

// File: tb/tb_sprite_layer_scheduler.sv
// Directed bench for sprite_layer_scheduler with a synchronous ROM model.
// ROM texel = addr[1:0] ^ addr[8:7]; SPRITE_FLIP_EN adds the mirror step.
module tb_sprite_layer_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY;
  logic       blank;
  logic       cfg_valid, cfg_ready;
  logic [1:0] cfg_slot;
  logic [9:0] cfg_x, cfg_y;
  logic [1:0] cfg_img;
  logic       cfg_en;
`ifdef SPRITE_FLIP_EN
  logic       cfg_flip_h;
`endif
  logic [9:0] rom_address;
  logic [1:0] rom_q = 2'd0;
  logic       pix_valid, pix_hit;
  logic [1:0] pix_index;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  sprite_layer_scheduler dut (
    .vga_clk    (clk),
    .reset_n    (reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_slot   (cfg_slot),
    .cfg_x      (cfg_x),
    .cfg_y      (cfg_y),
    .cfg_img    (cfg_img),
    .cfg_en     (cfg_en),
`ifdef SPRITE_FLIP_EN
    .cfg_flip_h (cfg_flip_h),
`endif
    .rom_address(rom_address),
    .rom_q      (rom_q),
    .pix_valid  (pix_valid),
    .pix_hit    (pix_hit),
    .pix_index  (pix_index),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q <= rom_address[1:0] ^ rom_address[8:7];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input int x, input int y, input logic b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    tick();
  endtask

  task automatic wr(input int s, input int x, input int y,
                    input int img, input logic en, input logic fl);
    cfg_slot  = 2'(s);
    cfg_x     = 10'(x);
    cfg_y     = 10'(y);
    cfg_img   = 2'(img);
    cfg_en    = en;
`ifdef SPRITE_FLIP_EN
    cfg_flip_h = fl;
`endif
    if (fl) begin
      cfg_valid = 1'b1;
    end
    cfg_valid = 1'b1;
    chk("wr_ready", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic commit_frame();
    px(0, 480, 1'b0);
    px(0, 481, 1'b0);
    px(0, 0, 1'b0);
  endtask

  initial begin
    reset_n   = 1'b0;
    DrawX     = '0;
    DrawY     = 10'd500;
    blank     = 1'b0;
    cfg_valid = 1'b0;
    cfg_slot  = '0;
    cfg_x     = '0;
    cfg_y     = '0;
    cfg_img   = '0;
    cfg_en    = 1'b0;
`ifdef SPRITE_FLIP_EN
    cfg_flip_h = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_addr", 32'(rom_address), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_hit", 32'(pix_hit), 32'd0);
    chk("rst_index", 32'(pix_index), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);

    reset_n = 1'b1;
    px(0, 300, 1'b0);
    chk("fs_idle", 32'(frame_start), 32'd0);
    px(0, 0, 1'b0);
    chk("fs_pulse", 32'(frame_start), 32'd1);
    px(0, 1, 1'b0);
    chk("fs_drop", 32'(frame_start), 32'd0);

    wr(0, 100, 50, 0, 1'b1, 1'b0);
    px(110, 60, 1'b1);
    chk("pre_commit", 32'(rom_address), 32'd0);
    px(0, 480, 1'b0);
    chk("commit_ready", 32'(cfg_ready), 32'd0);
    px(0, 481, 1'b0);
    chk("vblank_ready", 32'(cfg_ready), 32'd1);
    px(0, 0, 1'b0);
    chk("fs_frame2", 32'(frame_start), 32'd1);

    px(100, 50, 1'b1);
    chk("addr_tl", 32'(rom_address), 32'd0);
    px(127, 77, 1'b1);
    chk("addr_br", 32'(rom_address), 32'd195);
    px(128, 50, 1'b1);
    chk("addr_clip", 32'(rom_address), 32'd0);
    chk("hit_br", 32'(pix_hit), 32'd1);
    chk("index_br", 32'(pix_index), 32'd2);
    chk("valid_br", 32'(pix_valid), 32'd1);
    px(110, 60, 1'b0);
    chk("addr_mid", 32'(rom_address), 32'd75);
    chk("hit_clip", 32'(pix_hit), 32'd0);
    px(0, 100, 1'b0);
    chk("valid_blank", 32'(pix_valid), 32'd0);
    chk("hit_blank", 32'(pix_hit), 32'd0);

    wr(1, 100, 50, 2, 1'b1, 1'b0);
    commit_frame();
    px(100, 50, 1'b1);
    chk("prio_addr", 32'(rom_address), 32'd0);
    px(110, 60, 1'b1);
    chk("prio_addr2", 32'(rom_address), 32'd75);
    chk("transp_hit", 32'(pix_hit), 32'd0);
    chk("transp_index", 32'(pix_index), 32'd0);
    chk("transp_valid", 32'(pix_valid), 32'd1);

    px(0, 100, 1'b0);
    wr(0, 200, 50, 0, 1'b1, 1'b0);
    px(100, 60, 1'b1);
    chk("tear_old", 32'(rom_address), 32'd70);
    px(200, 60, 1'b1);
    chk("tear_new_early", 32'(rom_address), 32'd0);
    commit_frame();
    px(200, 60, 1'b1);
    chk("tear_moved", 32'(rom_address), 32'd70);
    px(100, 60, 1'b1);
    chk("tear_slot1", 32'(rom_address), 32'd462);

    DrawX     = '0;
    DrawY     = 10'd480;
    blank     = 1'b0;
    cfg_slot  = 2'd3;
    cfg_x     = 10'd400;
    cfg_y     = 10'd400;
    cfg_img   = 2'd3;
    cfg_en    = 1'b1;
    cfg_valid = 1'b1;
    chk("hs_ready_disp", 32'(cfg_ready), 32'd1);
    tick();
    cfg_slot = 2'd2;
    cfg_x    = 10'd300;
    cfg_y    = 10'd300;
    cfg_img  = 2'd1;
    DrawY    = 10'd481;
    chk("hs_ready_commit", 32'(cfg_ready), 32'd0);
    tick();
    chk("hs_ready_after", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    px(0, 0, 1'b0);
    px(400, 400, 1'b1);
    chk("same_cycle_wr", 32'(rom_address), 32'd588);
    px(300, 300, 1'b1);
    chk("late_wr_hidden", 32'(rom_address), 32'd0);
    commit_frame();
    px(300, 300, 1'b1);
    chk("late_wr_shown", 32'(rom_address), 32'd196);

    px(100, 60, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_addr", 32'(rom_address), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    chk("arst_valid", 32'(pix_valid), 32'd0);
    #2;
    reset_n = 1'b1;
    px(300, 300, 1'b1);
    chk("arst_cleared", 32'(rom_address), 32'd0);
    chk("arst_no_fs", 32'(frame_start), 32'd0);
    px(0, 0, 1'b0);
    chk("arst_fs", 32'(frame_start), 32'd1);

`ifdef SPRITE_FLIP_EN
    wr(0, 100, 50, 0, 1'b1, 1'b1);
    commit_frame();
    px(100, 50, 1'b1);
    chk("flip_addr", 32'(rom_address), 32'd13);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
